// File: rtl/tack_engine.sv
// tack_engine: multi-channel MC68040/MC68060 transfer-acknowledge generator.
// Runs on CLK80; CLK40 is only a phase qualifier for the TS sample.
// Each channel has a programmable delay and optional 4-beat burst support.
// A watchdog ends unclaimed cycles with TACK, or with TEA if TIMEOUT_TEA is set.
// Outputs are registered and decoded from the next state.
module tack_engine #(
  parameter int NCH         = 4,
  parameter int DW          = 4,
  parameter int TAIL        = 3,
  parameter int TIMEOUT     = 249,
  parameter int TIMEOUT_TEA = 0
) (
  input  logic              CLK80,
  input  logic              RESETn,
  input  logic              CLK40,
  input  logic              TSn,
  input  logic              BURST,
  input  logic [NCH-1:0]    CH_SEL,
  input  logic [NCH*DW-1:0] CH_DELAY,
  input  logic [NCH-1:0]    CH_BURST_OK,
  input  logic              SNOOP_SPACE,
  input  logic              TACK_INn,
  output logic              TACK_OE,
  output logic              TACK_OUTn,
  output logic              TEA_OE,
  output logic              TEA_OUTn,
  output logic [NCH-1:0]    CH_ACTIVE,
  output logic              BUSY
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int TW = $clog2(TAIL + 2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DELAY    = 3'd1,
    S_ACK      = 3'd2,
    S_NEGATE   = 3'd3,
    S_TAILWAIT = 3'd4,
    S_WATCH    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [NCH-1:0]  win_q, win_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic [DW-1:0]   dly_cnt_q, dly_cnt_d;
  logic [WW-1:0]   wd_cnt_q, wd_cnt_d;
  logic [1:0]      beat_q, beat_d;
  logic [1:0]      last_beat_q, last_beat_d;
  logic            phase_q, phase_d;
  logic [TW-1:0]   tail_cnt_q, tail_cnt_d;
  logic            wd_path_q, wd_path_d;

  logic            tack_oe_q, tack_oe_d;
  logic            tack_n_q, tack_n_d;
  logic            tea_oe_q, tea_oe_d;
  logic            tea_n_q, tea_n_d;
  logic [NCH-1:0]  ch_act_q, ch_act_d;
  logic            busy_q, busy_d;

  logic [NCH-1:0]  win_s;
  logic [DW-1:0]   win_dly_s;
  logic            win_bok_s;
  logic            start_s;
  logic [DW-1:0]   d_eff_s;
  logic            use_tea_s;
  logic            drive_s;
  logic            low_s;

  // Lowest-index selected channel and its delay / burst capability.
  always_comb begin
    win_s     = CH_SEL & (~CH_SEL + NCH'(1));
    win_dly_s = '0;
    for (int i = 0; i < NCH; i++) begin
      win_dly_s = win_dly_s | (CH_DELAY[i*DW +: DW] & {DW{win_s[i]}});
    end
    win_bok_s = |(win_s & CH_BURST_OK);
  end

  assign start_s = (state_q == S_IDLE) && CLK40 && !TSn;
  // A programmed delay of 0 behaves like 1.
  assign d_eff_s = (dly_q == '0) ? DW'(1) : dly_q;

  // Next-state logic and counter updates.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    dly_d       = dly_q;
    dly_cnt_d   = dly_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    beat_d      = beat_q;
    last_beat_d = last_beat_q;
    phase_d     = phase_q;
    tail_cnt_d  = tail_cnt_q;
    wd_path_d   = wd_path_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          beat_d    = 2'd0;
          phase_d   = 1'b0;
          dly_cnt_d = '0;
          wd_cnt_d  = '0;
          if (|CH_SEL) begin
            state_d     = S_DELAY;
            win_d       = win_s;
            dly_d       = win_dly_s;
            last_beat_d = (BURST && win_bok_s) ? 2'd3 : 2'd0;
            wd_path_d   = 1'b0;
          end else begin
            state_d     = S_WATCH;
            win_d       = '0;
            dly_d       = '0;
            last_beat_d = 2'd0;
            wd_path_d   = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DELAY: begin
        if (dly_cnt_q == d_eff_s) begin
          state_d = S_ACK;
        end else begin
          dly_cnt_d = dly_cnt_q + 1'b1;
        end
      end
      S_ACK: begin
        // Each beat is two cycles: phase 0 then phase 1.
        if (phase_q) begin
          phase_d = 1'b0;
          if (beat_q == last_beat_q) begin
            state_d = S_NEGATE;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end else begin
          phase_d = 1'b1;
        end
      end
      S_NEGATE: begin
        // Watchdog-terminated cycles release without a tail.
        if (wd_path_q || (TAIL == 0)) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_TAILWAIT;
          tail_cnt_d = '0;
        end
      end
      S_TAILWAIT: begin
        if (tail_cnt_q == TW'(TAIL - 1)) begin
          state_d = S_IDLE;
        end else begin
          tail_cnt_d = tail_cnt_q + 1'b1;
        end
      end
      S_WATCH: begin
        // Another agent claimed the cycle: abort with no drive.
        if (SNOOP_SPACE || !TACK_INn) begin
          state_d  = S_IDLE;
          wd_cnt_d = '0;
        end else if (wd_cnt_q == WW'(TIMEOUT)) begin
          state_d     = S_ACK;
          beat_d      = 2'd0;
          phase_d     = 1'b0;
          last_beat_d = 2'd0;
        end else if (wd_cnt_q < WW'(TIMEOUT)) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so outputs can be registered.
  always_comb begin
    use_tea_s = wd_path_d && (TIMEOUT_TEA != 0);
    drive_s   = (state_d == S_ACK) || (state_d == S_NEGATE);
    low_s     = (state_d == S_ACK);
    tack_oe_d = drive_s && !use_tea_s;
    tack_n_d  = !(low_s && !use_tea_s);
    tea_oe_d  = drive_s && use_tea_s;
    tea_n_d   = !(low_s && use_tea_s);
    busy_d    = (state_d != S_IDLE);
    if ((state_d == S_DELAY) || (state_d == S_ACK) ||
        (state_d == S_NEGATE) || (state_d == S_TAILWAIT)) begin
      ch_act_d = win_d;
    end else begin
      ch_act_d = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= S_IDLE;
      win_q       <= '0;
      dly_q       <= '0;
      dly_cnt_q   <= '0;
      wd_cnt_q    <= '0;
      beat_q      <= 2'd0;
      last_beat_q <= 2'd0;
      phase_q     <= 1'b0;
      tail_cnt_q  <= '0;
      wd_path_q   <= 1'b0;
      tack_oe_q   <= 1'b0;
      tack_n_q    <= 1'b1;
      tea_oe_q    <= 1'b0;
      tea_n_q     <= 1'b1;
      ch_act_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      dly_q       <= dly_d;
      dly_cnt_q   <= dly_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      beat_q      <= beat_d;
      last_beat_q <= last_beat_d;
      phase_q     <= phase_d;
      tail_cnt_q  <= tail_cnt_d;
      wd_path_q   <= wd_path_d;
      tack_oe_q   <= tack_oe_d;
      tack_n_q    <= tack_n_d;
      tea_oe_q    <= tea_oe_d;
      tea_n_q     <= tea_n_d;
      ch_act_q    <= ch_act_d;
      busy_q      <= busy_d;
    end
  end

  assign TACK_OE   = tack_oe_q;
  assign TACK_OUTn = tack_n_q;
  assign TEA_OE    = tea_oe_q;
  assign TEA_OUTn  = tea_n_q;
  assign CH_ACTIVE = ch_act_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_tack_engine.sv
// Testbench for tack_engine: two instances (watchdog ends with TACK / with TEA)
// share all inputs. A transaction-level model predicts every output each cycle,
// and directed literal checks pin the model against hand-computed timing.
module tb_tack_engine;

  localparam int TAIL_P = 3;
  localparam int TMO    = 249;

  logic        clk80, rst_n, clk40, tsn, burst, snoop, tack_in;
  logic [3:0]  ch_sel, ch_bok;
  logic [15:0] ch_delay;

  logic       a_tack_oe, a_tack_n, a_tea_oe, a_tea_n, a_busy;
  logic [3:0] a_ch;
  logic       b_tack_oe, b_tack_n, b_tea_oe, b_tea_n, b_busy;
  logic [3:0] b_ch;

  int n_vec = 0;
  int n_bad = 0;

  tack_engine #(.NCH(4), .DW(4), .TAIL(TAIL_P), .TIMEOUT(TMO), .TIMEOUT_TEA(0)) u_a (
    .CLK80(clk80), .RESETn(rst_n), .CLK40(clk40), .TSn(tsn), .BURST(burst),
    .CH_SEL(ch_sel), .CH_DELAY(ch_delay), .CH_BURST_OK(ch_bok),
    .SNOOP_SPACE(snoop), .TACK_INn(tack_in),
    .TACK_OE(a_tack_oe), .TACK_OUTn(a_tack_n), .TEA_OE(a_tea_oe), .TEA_OUTn(a_tea_n),
    .CH_ACTIVE(a_ch), .BUSY(a_busy)
  );

  tack_engine #(.NCH(4), .DW(4), .TAIL(TAIL_P), .TIMEOUT(TMO), .TIMEOUT_TEA(1)) u_b (
    .CLK80(clk80), .RESETn(rst_n), .CLK40(clk40), .TSn(tsn), .BURST(burst),
    .CH_SEL(ch_sel), .CH_DELAY(ch_delay), .CH_BURST_OK(ch_bok),
    .SNOOP_SPACE(snoop), .TACK_INn(tack_in),
    .TACK_OE(b_tack_oe), .TACK_OUTn(b_tack_n), .TEA_OE(b_tea_oe), .TEA_OUTn(b_tea_n),
    .CH_ACTIVE(b_ch), .BUSY(b_busy)
  );

  initial begin
    clk80 = 1'b0;
    forever #5 clk80 = ~clk80;
  end

  initial begin
    clk40 = 1'b0;
    forever begin
      @(posedge clk80);
      #1 clk40 = ~clk40;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Packed view: {oe, outn, tea_oe, tea_n, ch[3:0], busy}
  localparam logic [8:0] IDLE_V = 9'b0_1_0_1_0000_0;
  int         cyc = 0;
  int         m_start = 0, m_d = 0, m_len = 0, m_last = 0;
  bit         m_busy = 1'b0, m_watch = 1'b0;
  logic [3:0] m_win = 4'd0;
  logic [8:0] ex_a = IDLE_V, ex_b = IDLE_V;

  task automatic model_step();
    int n;
    int w;
    logic low, oe;
    cyc++;
    if (!rst_n) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (clk40 && !tsn) begin
        m_busy  = 1'b1;
        m_start = cyc;
        m_watch = (ch_sel == 4'd0);
        m_win   = 4'd0;
        if (m_watch) begin
          m_d   = TMO;
          m_len = 2;
        end else begin
          w = -1;
          for (int i = 0; i < 4; i++) if (ch_sel[i] && w < 0) w = i;
          m_win[w] = 1'b1;
          m_d = int'(ch_delay[w*4 +: 4]);
          if (m_d == 0) m_d = 1;
          m_len = (burst && ch_bok[w]) ? 8 : 2;
        end
        m_last = m_d + m_len + 2 + (m_watch ? 0 : TAIL_P);
      end
    end else begin
      n = cyc - m_start;
      if (m_watch && n >= 1 && n <= m_d + 1 && (snoop || !tack_in)) m_busy = 1'b0;
      else if (n == m_last) m_busy = 1'b0;
    end
    n = cyc - m_start;
    ex_a = IDLE_V;
    ex_b = IDLE_V;
    if (m_busy) begin
      low  = (n >= m_d + 1) && (n <= m_d + m_len);
      oe   = (n >= m_d + 1) && (n <= m_d + m_len + 1);
      ex_a = {oe, !low, 1'b0, 1'b1, (m_watch ? 4'd0 : m_win), 1'b1};
      ex_b = m_watch ? {1'b0, 1'b1, oe, !low, 4'd0, 1'b1} : ex_a;
    end
  endtask

  // Model update on each rising edge, compare on the following falling edge.
  initial begin
    forever begin
      @(posedge clk80);
      model_step();
      @(negedge clk80);
      if (!rst_n) begin
        ex_a = IDLE_V;
        ex_b = IDLE_V;
      end
      check("model inst_a", {23'd0, a_tack_oe, a_tack_n, a_tea_oe, a_tea_n, a_ch, a_busy}, {23'd0, ex_a});
      check("model inst_b", {23'd0, b_tack_oe, b_tack_n, b_tea_oe, b_tea_n, b_ch, b_busy}, {23'd0, ex_b});
    end
  end

  // ---------------- directed stimulus ----------------
  int e_now = 0;

  task automatic adv(input int k);
    while (e_now < k) begin
      @(posedge clk80);
      e_now++;
    end
    #2;
  endtask

  // Present a qualified TS so that the next rising edge is E0.
  task automatic start_tx(input logic [3:0] sel, input logic [15:0] dly,
                          input logic bst, input logic [3:0] bok);
    @(posedge clk80);
    #2;
    if (!clk40) begin
      @(posedge clk80);
      #2;
    end
    tsn = 1'b0; ch_sel = sel; ch_delay = dly; burst = bst; ch_bok = bok;
    @(posedge clk80);
    #2;
    tsn = 1'b1;
    e_now = 0;
  endtask

  initial begin
    rst_n = 1'b0; tsn = 1'b1; burst = 1'b0; snoop = 1'b0; tack_in = 1'b1;
    ch_sel = 4'd0; ch_bok = 4'd0; ch_delay = 16'd0;
    #12;
    check("reset tack_oe", {31'd0, a_tack_oe}, 32'd0);
    check("reset tack_n", {31'd0, a_tack_n}, 32'd1);
    check("reset busy", {31'd0, a_busy}, 32'd0);
    #10 rst_n = 1'b1;

    // Single beat, channel 1, d=5
    start_tx(4'b0010, 16'h0053, 1'b0, 4'b1111);
    adv(1);  check("t1 ch E1", {28'd0, a_ch}, 32'h2);
    adv(6);  check("t1 tack low E6", {30'd0, a_tack_oe, a_tack_n}, 32'h2);
    adv(7);  check("t1 tack low E7", {31'd0, a_tack_n}, 32'd0);
    adv(8);  check("t1 negate E8", {30'd0, a_tack_oe, a_tack_n}, 32'h3);
    adv(9);  check("t1 release E9", {31'd0, a_tack_oe}, 32'd0);
    adv(11); check("t1 ch E11", {28'd0, a_ch}, 32'h2);
    adv(12); check("t1 ch clear E12", {27'd0, a_ch, a_busy}, 32'd0);
    adv(14);

    // Priority and latching: ch1 (d=1) beats ch3 (d=9)
    start_tx(4'b1010, 16'h9010, 1'b0, 4'b0000);
    ch_sel = 4'b0001; ch_delay = 16'hFFFF;
    adv(1);  check("t2 ch E1", {28'd0, a_ch}, 32'h2);
    adv(2);  check("t2 tack low E2", {31'd0, a_tack_n}, 32'd0);
    adv(4);  check("t2 tack high E4", {31'd0, a_tack_n}, 32'd1);
    adv(7);  check("t2 busy E7", {31'd0, a_busy}, 32'd1);
    adv(8);  check("t2 idle E8", {31'd0, a_busy}, 32'd0);
    adv(10);

    // Burst on a burst-capable channel
    start_tx(4'b0001, 16'h0002, 1'b1, 4'b0001);
    adv(3);  check("t3 burst low E3", {31'd0, a_tack_n}, 32'd0);
    adv(10); check("t3 burst low E10", {31'd0, a_tack_n}, 32'd0);
    adv(11); check("t3 burst high E11", {31'd0, a_tack_n}, 32'd1);
    adv(12); check("t3 burst release E12", {31'd0, a_tack_oe}, 32'd0);
    adv(15); check("t3 burst idle E15", {31'd0, a_busy}, 32'd0);
    adv(17);

    // Burst requested but channel not capable
    start_tx(4'b0001, 16'h0002, 1'b1, 4'b0000);
    adv(3);  check("t3b low E3", {31'd0, a_tack_n}, 32'd0);
    adv(5);  check("t3b high E5", {31'd0, a_tack_n}, 32'd1);
    adv(6);  check("t3b release E6", {31'd0, a_tack_oe}, 32'd0);
    adv(10);

    // Delay 0 acts as 1; SNOOP_SPACE during a channel cycle has no effect
    start_tx(4'b0100, 16'h0000, 1'b0, 4'b0000);
    snoop = 1'b1;
    adv(1);  check("t4 ch E1", {28'd0, a_ch}, 32'h4);
    adv(2);  check("t4 low E2", {31'd0, a_tack_n}, 32'd0);
    adv(4);  check("t4 high E4", {31'd0, a_tack_n}, 32'd1);
    snoop = 1'b0;
    adv(8);  check("t4 idle E8", {31'd0, a_busy}, 32'd0);
    adv(10);

    // TS with CLK40 low is ignored
    @(posedge clk80);
    #2;
    if (clk40) begin
      @(posedge clk80);
      #2;
    end
    tsn = 1'b0; ch_sel = 4'b0001;
    @(posedge clk80);
    #2;
    tsn = 1'b1;
    check("t5 clk40 low ignored", {31'd0, a_busy}, 32'd0);
    repeat (3) @(posedge clk80);

    // Watchdog, both termination modes
    start_tx(4'b0000, 16'h0000, 1'b0, 4'b0000);
    adv(249); check("t6 watch E249", {30'd0, a_busy, a_tack_oe}, 32'h2);
    adv(250); check("t6 a tack low E250", {30'd0, a_tack_oe, a_tack_n}, 32'h2);
              check("t6 a tea idle", {30'd0, a_tea_oe, a_tea_n}, 32'h1);
              check("t6 b tea low E250", {30'd0, b_tea_oe, b_tea_n}, 32'h2);
              check("t6 b tack idle", {30'd0, b_tack_oe, b_tack_n}, 32'h1);
    adv(252); check("t6 a negate E252", {30'd0, a_tack_oe, a_tack_n}, 32'h3);
    adv(253); check("t6 release E253", {28'd0, a_tack_oe, a_busy, b_tea_oe, b_busy}, 32'd0);
    adv(255);

    // Watchdog abort by observed TACK
    start_tx(4'b0000, 16'h0000, 1'b0, 4'b0000);
    adv(39); tack_in = 1'b0;
    adv(40); check("t7 abort tack_in", {29'd0, a_busy, a_tack_oe, b_tea_oe}, 32'd0);
    tack_in = 1'b1;
    adv(42);

    // Watchdog abort by snoop
    start_tx(4'b0000, 16'h0000, 1'b0, 4'b0000);
    adv(9);  check("t8 busy E9", {31'd0, a_busy}, 32'd1);
    snoop = 1'b1;
    adv(10); check("t8 abort snoop", {31'd0, a_busy}, 32'd0);
    snoop = 1'b0;
    adv(12);

    // Asynchronous reset while TACK is low
    start_tx(4'b0010, 16'h0050, 1'b0, 4'b0000);
    adv(6);  check("t9 low before reset", {31'd0, a_tack_n}, 32'd0);
    #1 rst_n = 1'b0;
    #1 check("t9 reset immediate", {25'd0, a_tack_oe, a_tack_n, a_ch, a_busy}, 32'h20);
    repeat (2) @(posedge clk80);
    #4 rst_n = 1'b1;
    start_tx(4'b0001, 16'h0003, 1'b0, 4'b0000);
    adv(4);  check("t9 post-reset low E4", {31'd0, a_tack_n}, 32'd0);
    adv(6);  check("t9 post-reset high E6", {31'd0, a_tack_n}, 32'd1);
    adv(10); check("t9 post-reset idle E10", {31'd0, a_busy}, 32'd0);
    adv(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tack_engine.md
# tack_engine

Parametrised, multi-channel MC68040/MC68060 transfer-acknowledge generator for U409, clocked by CLK80 (2× the 40 MHz bus clock). It replaces fixed per-source TACK logic with NCH channels, each with a runtime-programmable delay, optional burst (line-transfer) support and a one-hot chip enable. A watchdog terminates unclaimed cycles with TACK or TEA. TACK/TEA are produced as separate output-enable and level pairs; the top level builds the open bus drivers.

## Interface
Parameters:
- NCH, 4: number of acknowledge channels (1–8).
- DW, 4: width of each channel delay field.
- TAIL, 3: CLK80 cycles CH_ACTIVE stays asserted after final TACK negation.
- TIMEOUT, 249: watchdog expiry, in CLK80 cycles after the TS sample.
- TIMEOUT_TEA, 0: 0 = watchdog ends the cycle with TACK; 1 = watchdog ends it with TEA.

Ports:
- CLK80  in  1  system clock; every register uses its rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- CLK40  in  1  bus-clock phase qualifier, sampled as data.
- TSn  in  1  CPU transfer start, active low.
- BURST  in  1  line transfer (SIZ = line), sampled with TSn.
- CH_SEL  in  NCH  per-channel address decode, sampled with TSn.
- CH_DELAY  in  NCH*DW  packed per-channel delay; channel i occupies [i*DW +: DW].
- CH_BURST_OK  in  NCH  channel i supports 4-beat bursts.
- SNOOP_SPACE  in  1  another agent owns the cycle; holds the watchdog cleared.
- TACK_INn  in  1  observed bus TACK; clears the watchdog.
- TACK_OE  out  1  drive TACK.
- TACK_OUTn  out  1  TACK level.
- TEA_OE  out  1  drive TEA.
- TEA_OUTn  out  1  TEA level.
- CH_ACTIVE  out  NCH  one-hot active-channel enable.
- BUSY  out  1  engine not in IDLE.

## Operation
- Reset values: TACK_OE=0, TACK_OUTn=1, TEA_OE=0, TEA_OUTn=1, CH_ACTIVE=0, BUSY=0, FSM=IDLE, all counters 0.
- Qualified start: rising edge with CLK40=1, TSn=0 and FSM=IDLE. TSn is ignored at any other time.
- At the start edge:
  - CH_SEL, BURST and the selected delay are latched.
  - The lowest-index set CH_SEL bit wins.
  - Beat count = 4 if BURST and CH_BURST_OK[winner] are both 1, otherwise 1.
- FSM states:
  - IDLE → DELAY when a channel is selected. CH_ACTIVE[winner]=1 from the next cycle.
  - IDLE → WATCH when no channel is selected.
  - DELAY: counts up to the latched delay d (d=0 is treated as 1), then → ACK.
  - ACK: TACK_OE=1, TACK_OUTn=0 for exactly 2 cycles per beat. Beats run back-to-back, so a burst holds TACK low for 8 cycles. Then → NEGATE.
  - NEGATE: TACK_OUTn=1 with OE held for 1 cycle, then OE=0 → TAILWAIT.
  - TAILWAIT: TAIL cycles, then CH_ACTIVE=0 → IDLE.
  - WATCH: the watchdog counts. If SNOOP_SPACE=1 or TACK_INn=0, → IDLE with no drive. At count TIMEOUT, → ACK with 1 beat, using the TEA pair instead of TACK when TIMEOUT_TEA=1.
- Width and arithmetic:
  - The delay counter is DW bits.
  - The watchdog counter is clog2(TIMEOUT+1) bits and saturates; it never wraps.
  - The beat counter is 2 bits.
- Boundary rules:
  - CH_SEL and CH_DELAY changes after the start edge are ignored.
  - The engine's own TACK drive never clears the watchdog, because the watchdog is only live in WATCH.
  - SNOOP_SPACE during a channel cycle has no effect.
  - RESETn low at any point returns all outputs to reset values immediately; no negate cycle is generated.
  - TACK_OE and TEA_OE are never both 1.

## Timing
Edge numbering: E0 = start edge.
- Channel path, delay d, single beat:
  - CH_ACTIVE high after E0.
  - TACK_OE=1 and TACK_OUTn=0 after edge E(d+1); low for 2 cycles.
  - TACK_OUTn=1 after E(d+3); OE=0 after E(d+4).
  - CH_ACTIVE=0 after E(d+4+TAIL).
  - BUSY falls on the same edge as CH_ACTIVE.
- Burst: TACK low from E(d+1) to E(d+9); all later events shift by +6.
- Watchdog: TACK/TEA low after E(TIMEOUT+1) for 2 cycles, then 1 negate cycle, then release. WATCH exits to IDLE with no tail.
- Earliest next start: the edge after IDLE is re-entered.

## Test plan
- Single-beat cycle: NCH=4, CH_SEL=0010, CH_DELAY[1]=5, BURST=0 → CH_ACTIVE=0010 from E1; TACK low E6–E8; OE released at E9; CH_ACTIVE clears at E12 (TAIL=3).
- Priority and latching: CH_SEL=1010, CH_DELAY[1]=1, CH_DELAY[3]=9 → channel 1 wins and TACK is low E2–E4. A CH_SEL change after E0 alters nothing.
- Burst gating:
  - BURST=1, CH_BURST_OK[0]=1, d=2 → TACK low E3–E11.
  - Same cycle with CH_BURST_OK[0]=0 → single beat, TACK low E3–E5.
- Watchdog, both modes, no CH_SEL:
  - TIMEOUT_TEA=0 → TACK low E250–E252, TEA idle.
  - TIMEOUT_TEA=1 → TEA low E250–E252, TACK_OE stays 0.
- Watchdog abort: no CH_SEL, drive TACK_INn=0 at E40 → BUSY=0 next cycle, no drive. SNOOP_SPACE=1 gives the same result.
- Reset mid-operation: assert RESETn=0 while TACK is low → TACK_OE=0, TACK_OUTn=1 and CH_ACTIVE=0 immediately, without waiting for a clock. TSn qualified after reset release is accepted normally.
